// File: rtl/mem_io_pkg.sv
// Shared constants for the memory/IO responder: address map and RAM sizing.
package mem_io_pkg;

    // RAM sizing
    localparam int RAM_ADDR_W = 17;
    localparam int RAM_BYTES  = 1 << RAM_ADDR_W;

    // IO window: 0x30000, selected by address bits [17:16]
    localparam logic [31:0] IO_BASE = 32'h0003_0000;
    localparam logic [1:0]  IO_TAG  = 2'b11;

    // IO register offsets within the window
    localparam logic [15:0] IO_UART = 16'h0000;
    localparam logic [15:0] IO_CLK  = 16'h0004;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_UNMAPPED,
        REG_IO
    } region_e;

    // Classify an access by address bits [17:16]
    function automatic region_e decode_region(input logic [1:0] tag);
        if (tag == IO_TAG)      return REG_IO;
        else if (tag == 2'b10)  return REG_UNMAPPED;
        else                    return REG_RAM;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head output; head reads as zero when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? '0 : store[rd_ptr];

    // Storage array: written on accepted pushes, never reset
    always_ff @(posedge clk_in) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide responder for the core's memory port: 128 KB RAM, IO window at
// 0x30000 (host RX byte, TX FIFO, cycle counter, program-stop flag).
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_W,
    parameter int TX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_addr,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic        tx_overflow
);
    logic [7:0]            ram [1 << ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [15:0]           io_off;
    region_e               region;

    logic [31:0] cnt;
    logic [31:0] cnt_snap;
    logic [7:0]  rd_byte;
    logic        snap_load;
    logic        push_req;
    logic        halt_set;
    logic        halt_req;
    logic        halt_latched;
    logic        tx_pop;
    logic        tx_full;
    logic        tx_empty;

    // Upper address bits are don't-care; the low snapshot byte is served live from cnt
    logic unused_ok;
    assign unused_ok = &{1'b0, mem_addr[31:18], cnt_snap[7:0]};

    assign ram_idx = mem_addr[ADDR_WIDTH-1:0];
    assign io_off  = mem_addr[15:0];
    assign region  = decode_region(mem_addr[17:16]);

    // Address decode: read byte selection plus IO side-effect strobes
    always_comb begin
        rd_byte   = 8'h00;
        rx_pop    = 1'b0;
        snap_load = 1'b0;
        push_req  = 1'b0;
        halt_set  = 1'b0;
        if (region == REG_RAM) begin
            rd_byte = ram[ram_idx];
        end else if (region == REG_IO) begin
            case (io_off)
                IO_UART: begin
                    if (!mem_wr && rx_valid) begin
                        rd_byte = rx_data;
                        rx_pop  = 1'b1;
                    end
                    push_req = mem_wr && (mem_dout != 8'h00);
                end
                IO_CLK: begin
                    rd_byte   = cnt[7:0];
                    snap_load = ~mem_wr;
                    halt_set  = mem_wr;
                end
                IO_CLK + 16'd1: rd_byte = cnt_snap[15:8];
                IO_CLK + 16'd2: rd_byte = cnt_snap[23:16];
                IO_CLK + 16'd3: rd_byte = cnt_snap[31:24];
                default:        rd_byte = 8'h00;
            endcase
        end
    end

    // RAM write port; unmapped and IO writes never reach the array
    always_ff @(posedge clk_in) begin
        if (mem_wr && region == REG_RAM) ram[ram_idx] <= mem_dout;
    end

    // Read-data register: loads on every non-write cycle, holds across writes
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) mem_din <= 8'h00;
        else if (!mem_wr) mem_din <= rd_byte;
    end

    // Free-running cycle counter and the snapshot taken when byte 0 is read
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt      <= '0;
            cnt_snap <= '0;
        end else begin
            cnt <= cnt + 32'd1;
            if (snap_load) cnt_snap <= cnt;
        end
    end

    // Sticky status: stop request, latched halt, and dropped-byte flag
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            halt_req     <= 1'b0;
            halt_latched <= 1'b0;
            tx_overflow  <= 1'b0;
        end else begin
            if (halt_set) halt_req <= 1'b1;
            if (halt_req && !tx_valid) halt_latched <= 1'b1;
            if (push_req && tx_full && !tx_pop) tx_overflow <= 1'b1;
        end
    end

    // Halt appears as soon as the FIFO drains and then stays regardless of new pushes
    assign halt     = halt_latched | (halt_req & ~tx_valid);
    assign tx_valid = ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (push_req),
        .push_data (mem_dout),
        .pop       (tx_pop),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty)
    );

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM, RX read, TX FIFO, counter snapshot, halt, reset.
module tb_mem_io_responder;
    import mem_io_pkg::*;

    logic        clk_in;
    logic        rst_in;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        halt;
    logic        tx_overflow;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [31:0] A_IDLE = 32'h0002_0000;
    localparam logic [31:0] A_UART = IO_BASE + 32'(IO_UART);
    localparam logic [31:0] A_CLK  = IO_BASE + 32'(IO_CLK);

    mem_io_responder dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .mem_addr    (mem_addr),
        .mem_wr      (mem_wr),
        .mem_dout    (mem_dout),
        .mem_din     (mem_din),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_pop      (rx_pop),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .halt        (halt),
        .tx_overflow (tx_overflow)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [7:0] d);
        mem_addr = a;
        mem_wr   = w;
        mem_dout = d;
    endtask

    // Advance one rising edge and settle just after it
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        logic [7:0] exp_q [$];

        rst_in   = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        drive(A_IDLE, 1'b0, 8'h00);
        step();
        step();
        chk("rst_mem_din",  32'(mem_din),     32'h00);
        chk("rst_tx_valid", 32'(tx_valid),    32'h0);
        chk("rst_tx_data",  32'(tx_data),     32'h00);
        chk("rst_halt",     32'(halt),        32'h0);
        chk("rst_overflow", 32'(tx_overflow), 32'h0);
        chk("rst_rx_pop",   32'(rx_pop),      32'h0);
        rst_in = 1'b1;

        // RAM write then read on the next cycle
        drive(32'h0000_0010, 1'b1, 8'hA5);
        step();
        drive(32'h0000_0010, 1'b0, 8'h00);
        chk("wr_keeps_din", 32'(mem_din), 32'h00);
        step();
        chk("ram_rd_a5", 32'(mem_din), 32'hA5);

        // Host RX read with and without a byte available
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        drive(A_UART, 1'b0, 8'h00);
        #1;
        chk("rx_pop_hi", 32'(rx_pop), 32'h1);
        step();
        chk("rx_rd_41", 32'(mem_din), 32'h41);
        drive(A_IDLE, 1'b0, 8'h00);
        #1;
        chk("rx_pop_once", 32'(rx_pop), 32'h0);
        rx_valid = 1'b0;
        drive(A_UART, 1'b0, 8'h00);
        #1;
        chk("rx_pop_none", 32'(rx_pop), 32'h0);
        step();
        chk("rx_rd_empty", 32'(mem_din), 32'h00);

        // TX pushes with sink stalled; zero byte ignored, ninth entry dropped
        drive(A_UART, 1'b1, 8'h48);
        step();
        chk("tx_valid_1", 32'(tx_valid), 32'h1);
        chk("tx_head_48", 32'(tx_data),  32'h48);
        drive(A_UART, 1'b1, 8'h00);
        step();
        drive(A_UART, 1'b1, 8'h69);
        step();
        for (int i = 1; i <= 6; i++) begin
            drive(A_UART, 1'b1, 8'(i));
            step();
        end
        chk("tx_no_ovf_at_8", 32'(tx_overflow), 32'h0);
        drive(A_UART, 1'b1, 8'h07);
        step();
        chk("tx_ovf_set", 32'(tx_overflow), 32'h1);
        chk("tx_head_kept", 32'(tx_data), 32'h48);

        // Partial drain while reading RAM, then asynchronous reset mid-stream
        tx_ready = 1'b1;
        drive(32'h0000_0010, 1'b0, 8'h00);
        exp_q = '{8'h48, 8'h69, 8'h01, 8'h02};
        foreach (exp_q[i]) begin
            chk($sformatf("drain_%0d", i), 32'(tx_data), 32'(exp_q[i]));
            step();
        end
        chk("pre_rst_din",   32'(mem_din),  32'hA5);
        chk("pre_rst_valid", 32'(tx_valid), 32'h1);
        tx_ready = 1'b0;
        drive(A_IDLE, 1'b0, 8'h00);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_din",      32'(mem_din),     32'h00);
        chk("async_tx_valid", 32'(tx_valid),    32'h0);
        chk("async_tx_data",  32'(tx_data),     32'h00);
        chk("async_overflow", 32'(tx_overflow), 32'h0);

        // Counter snapshot: release at a falling edge so the 256th rising edge sees cnt=0xFF
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (255) @(posedge clk_in);
        #1;
        drive(A_CLK, 1'b0, 8'h00);
        step();
        chk("cnt_b0", 32'(mem_din), 32'hFF);
        exp_q = '{8'h00, 8'h00, 8'h00};
        foreach (exp_q[i]) begin
            drive(A_CLK + 32'(i + 1), 1'b0, 8'h00);
            step();
            chk($sformatf("cnt_b%0d", i + 1), 32'(mem_din), 32'(exp_q[i]));
        end

        // Unmapped region and other IO offsets
        drive(32'h0002_0010, 1'b1, 8'h77);
        step();
        drive(32'h0000_0010, 1'b0, 8'h00);
        step();
        chk("unmapped_no_alias", 32'(mem_din), 32'hA5);
        drive(32'h0002_0010, 1'b0, 8'h00);
        step();
        chk("unmapped_rd", 32'(mem_din), 32'h00);
        drive(32'h0000_0010, 1'b0, 8'h00);
        step();
        drive(IO_BASE + 32'h8, 1'b0, 8'h00);
        step();
        chk("io_other_rd", 32'(mem_din), 32'h00);

        // Halt waits for the queued bytes to drain, then sticks
        for (int i = 0; i < 3; i++) begin
            drive(A_UART, 1'b1, 8'h11 * 8'(i + 1));
            step();
        end
        drive(A_CLK, 1'b1, 8'h00);
        step();
        chk("halt_wait", 32'(halt), 32'h0);
        drive(A_IDLE, 1'b0, 8'h00);
        tx_ready = 1'b1;
        step();
        chk("halt_after_1", 32'(halt), 32'h0);
        step();
        chk("halt_after_2", 32'(halt), 32'h0);
        step();
        chk("halt_after_3", 32'(halt), 32'h1);
        tx_ready = 1'b0;
        drive(A_UART, 1'b1, 8'h55);
        step();
        chk("post_halt_push", 32'(tx_valid), 32'h1);
        chk("halt_sticky",    32'(halt),     32'h1);
        drive(A_IDLE, 1'b0, 8'h00);
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_halt", 32'(halt), 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;

        // Push and pop together on a full FIFO: accepted, no overflow
        for (int i = 0; i < 8; i++) begin
            drive(A_UART, 1'b1, 8'h80 + 8'(i));
            step();
        end
        tx_ready = 1'b1;
        drive(A_UART, 1'b1, 8'h99);
        step();
        chk("full_pp_no_ovf", 32'(tx_overflow), 32'h0);
        drive(A_IDLE, 1'b0, 8'h00);
        exp_q = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h99};
        foreach (exp_q[i]) begin
            chk($sformatf("full_pp_%0d", i), 32'(tx_data), 32'(exp_q[i]));
            step();
        end
        chk("full_pp_empty", 32'(tx_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
